usb_bit_unstuff: RTL and testbench
==================================

# usb_bit_unstuff

Parametrised USB receive-side bit unstuffer. Sits between the NRZI decoder and the bit-stream decoder. It passes a configurable number of header (PID) bits through untouched, then removes the stuffed bit after every run of RUN_LEN consecutive ones. Beyond the fixed-function unstuffer it adds a stuff-error check, packet abort on error or a re-sync, and a length count of emitted payload bits. It is bufferless, with a fixed one-cycle latency.

## Interface
- RUN_LEN, 6: ones-run length after which the next bit is a stuffed bit.
- HDR_BITS, 8: leading bits of each packet that are exempt from counting and removal; legal range 0..255.
- CHECK_STUFF, 1: when 1, a stuffed bit equal to 1 is an error.
- LEN_W, 11: width of the payload length count.
- clk, input, 1: clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: in_bit is valid this cycle.
- in_bit, input, 1: decoded bit.
- in_sop, input, 1: qualified by in_valid; this is the first bit of a packet.
- in_eop, input, 1: qualified by in_valid; this is the last bit of a packet.
- out_valid, output, 1: out_bit is valid.
- out_bit, output, 1: unstuffed bit.
- out_sop, output, 1: marks the first emitted bit.
- out_eop, output, 1: one-cycle end-of-packet pulse.
- out_len, output, LEN_W: number of emitted non-header bits; valid when out_eop=1.
- out_abort, output, 1: one-cycle pulse; the current packet is discarded.
- stuff_err, output, 1: one-cycle pulse on a stuff violation.

## Operation
- States: IDLE, HDR, BODY, ERR. Reset puts the FSM in IDLE and sets every output and counter to 0.
- Cycles with in_valid=0 change no state and produce no outputs.
- **IDLE**
  - in_valid & in_sop emits the bit with out_sop=1.
  - The next state is HDR when HDR_BITS>1. It is BODY when HDR_BITS≤1; with HDR_BITS=0 the first bit is also counted as a body bit.
  - Other bits are ignored.
- **HDR**
  - Every bit is emitted. A header counter increments.
  - When the counter reaches HDR_BITS, the FSM goes to BODY and the ones counter is cleared.
  - Header bits never affect the ones counter.
- **BODY**
  - If ones==RUN_LEN, the bit is stuffed. It is dropped (out_valid=0) and the ones counter is cleared.
  - If the stuffed bit is 1 and CHECK_STUFF=1, the block pulses stuff_err and out_abort, then goes to ERR. If that bit also carries in_eop, the block goes to IDLE instead and out_eop is not asserted.
  - Otherwise the bit is emitted and out_len increments.
  - The ones counter increments on a 1 and clears on a 0. Its width is $clog2(RUN_LEN+1).
- **ERR**
  - Bits are discarded until in_valid & in_eop, then the FSM goes to IDLE.
- **End of packet** (HDR or BODY, in_valid & in_eop)
  - out_eop pulses in the same output cycle as that bit, whether the bit was emitted or dropped.
  - out_len presents the final count. The FSM goes to IDLE and all counters clear.
  - Ending in HDR is a short packet: out_eop asserts normally and out_len=0.
- **Re-sync**: in_sop while in HDR, BODY or ERR pulses out_abort for the old packet, with no out_eop. That bit then starts a new packet exactly as from IDLE.
- **in_sop & in_eop together in IDLE**: a one-bit packet. out_sop, out_valid and out_eop assert together, with out_len=0.
- out_len saturates at 2^LEN_W−1.

## Timing
- All outputs are registered. Latency is exactly 1 cycle from the accepted input bit to out_valid, out_eop, out_abort and stuff_err.
- There is no back-pressure. The downstream consumer must accept one bit per cycle.
- out_len is stable only in the out_eop cycle; at other times it is don't-care.
- Any number of in_valid=0 gaps between bits is legal. Runs are counted on valid bits only.
- Asynchronous reset mid-packet returns the FSM to IDLE with no out_eop or out_abort. The next in_sop starts cleanly.

## Structure
- Package usb_rx_pkg:
  - unstuff_state_t enum {IDLE, HDR, BODY, ERR}
  - USB_RUN_LEN=6
  - USB_PID_BITS=8
- One sub-module, sat_counter #(W): en, clr and saturating count. It is instanced for the ones, header and length counters. The FSM is in the top module.

## Test plan
- Default parameters. Send 8 PID bits, then the 12 bits 111111 0 10110 with in_eop on the last bit → 19 bits out. The 0 after the six ones is removed. out_len=11 and out_eop is coincident with the final 0.
- Body 111111 1 with CHECK_STUFF=1 → stuff_err and out_abort each pulse once, 1 cycle after the 7th 1. No out_eop. Later bits are discarded until in_eop.
- in_eop on a stuffed bit, body 0111111 0 → out_eop asserts with out_valid=0 and out_len=7.
- Header 11111111, then 0 → all 8 header ones pass and the 0 is kept. A following run of six ones, then a 0, drops the 0.
- in_sop in mid-body → out_abort pulses and the new bit appears with out_sop=1. HDR_BITS=0 with sop&eop on one bit → out_sop, out_valid and out_eop pulse together with out_len=1.
- Random in_valid gaps plus rst_n asserted mid-body → identical output bits to the gapless run. After reset all outputs are 0 and the next packet decodes correctly.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
// Holds the unstuffer FSM state type and USB framing constants.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY,
    ERR
  } unstuff_state_t;

  localparam int USB_RUN_LEN  = 6;
  localparam int USB_PID_BITS = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clk, rst_n, en (count), clr (restart; with en loads 1), q.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  // clr together with en restarts the count at the current event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= en ? W'(1) : '0;
    end else if (en && q != '1) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/usb_bit_unstuff.sv
// USB receive bit unstuffer: header pass-through, stuff removal/check,
// abort/re-sync, payload length. Ports: in_* bit stream in, out_* out.
module usb_bit_unstuff
  import usb_rx_pkg::*;
#(
  parameter int RUN_LEN     = USB_RUN_LEN,
  parameter int HDR_BITS    = USB_PID_BITS,
  parameter bit CHECK_STUFF = 1'b1,
  parameter int LEN_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic             out_valid,
  output logic             out_bit,
  output logic             out_sop,
  output logic             out_eop,
  output logic [LEN_W-1:0] out_len,
  output logic             out_abort,
  output logic             stuff_err
);

  localparam int OW = $clog2(RUN_LEN + 1);
  localparam int HW = 8;

  unstuff_state_t state, nxt;

  logic [OW-1:0]    ones_q, ones_base;
  logic [HW-1:0]    hdr_q;
  logic [LEN_W-1:0] len_q, len_base, len_fin;

  logic start, hdr_last, body, stuffed, fin;
  logic v_n, sop_n, eop_n, abt_n, err_n;
  logic hdr_en, hdr_clr, ones_en, ones_clr, len_inc;

  assign start    = in_valid & in_sop;
  assign hdr_last = ({1'b0, hdr_q} + 9'd1) == 9'(HDR_BITS);

  // A start bit begins from zeroed counters regardless of stale state.
  assign ones_base = in_sop ? '0 : ones_q;
  assign len_base  = in_sop ? '0 : len_q;
  assign len_fin   = (len_inc && len_base != '1) ?
                     len_base + LEN_W'(1) : len_base;

  always_comb begin
    nxt      = state;
    v_n      = 1'b0;
    sop_n    = 1'b0;
    eop_n    = 1'b0;
    abt_n    = 1'b0;
    err_n    = 1'b0;
    hdr_en   = 1'b0;
    hdr_clr  = 1'b0;
    ones_en  = 1'b0;
    ones_clr = 1'b0;
    len_inc  = 1'b0;
    body     = 1'b0;
    stuffed  = 1'b0;
    fin      = 1'b0;
    if (in_valid) begin
      if (in_sop) begin
        abt_n    = (state != IDLE);
        v_n      = 1'b1;
        sop_n    = 1'b1;
        hdr_clr  = 1'b1;
        ones_clr = 1'b1;
        hdr_en   = (HDR_BITS > 1);
        body     = (HDR_BITS == 0);
        nxt      = (HDR_BITS > 1) ? HDR : BODY;
      end else begin
        unique case (state)
          HDR: begin
            v_n = 1'b1;
            if (hdr_last) begin
              hdr_clr  = 1'b1;
              ones_clr = 1'b1;
              nxt      = BODY;
            end else begin
              hdr_en = 1'b1;
            end
          end
          BODY: body = 1'b1;
          ERR:  if (in_eop) nxt = IDLE;
          default: ;
        endcase
      end
      if (body) begin
        stuffed = (ones_base == OW'(RUN_LEN));
        if (stuffed) begin
          ones_clr = 1'b1;
          if (in_bit && CHECK_STUFF) begin
            err_n = 1'b1;
            abt_n = 1'b1;
            nxt   = ERR;
          end
        end else begin
          v_n     = 1'b1;
          len_inc = 1'b1;
          if (in_bit) ones_en  = 1'b1;
          else        ones_clr = 1'b1;
        end
      end
      // A stuff error on the last bit aborts instead of ending cleanly.
      if (in_eop && (in_sop || state == HDR || state == BODY)) begin
        fin   = 1'b1;
        nxt   = IDLE;
        eop_n = !err_n;
      end
    end
  end

  sat_counter #(.W(OW)) u_ones (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ones_en & ~fin),
    .clr   (ones_clr | fin),
    .q     (ones_q)
  );

  sat_counter #(.W(HW)) u_hdr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hdr_en & ~fin),
    .clr   (hdr_clr | fin),
    .q     (hdr_q)
  );

  sat_counter #(.W(LEN_W)) u_len (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (len_inc & ~fin),
    .clr   (start | fin),
    .q     (len_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_len   <= '0;
      out_abort <= 1'b0;
      stuff_err <= 1'b0;
    end else begin
      state     <= nxt;
      out_valid <= v_n;
      out_bit   <= v_n & in_bit;
      out_sop   <= sop_n;
      out_eop   <= eop_n;
      out_len   <= eop_n ? len_fin : '0;
      out_abort <= abt_n;
      stuff_err <= err_n;
    end
  end

endmodule

// File: tb/tb_usb_bit_unstuff.sv
// Scoreboard bench for usb_bit_unstuff: default instance plus a
// HDR_BITS=0 instance, directed packets with hand-derived outputs.
module tb_usb_bit_unstuff;

  typedef struct packed {
    logic        v;
    logic        b;
    logic        sop;
    logic        eop;
    logic        abt;
    logic        err;
    logic [10:0] len;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic a_iv = 0, a_ib = 0, a_is = 0, a_ie = 0;
  logic b_iv = 0, b_ib = 0, b_is = 0, b_ie = 0;
  logic a_ov, a_ob, a_os, a_oe, a_oa, a_se;
  logic b_ov, b_ob, b_os, b_oe, b_oa, b_se;
  logic [10:0] a_ol, b_ol;

  ev_t qa[$];
  ev_t qb[$];
  int vec = 0;
  int bad = 0;

  always #5 clk = ~clk;

  usb_bit_unstuff u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_iv),
    .in_bit    (a_ib),
    .in_sop    (a_is),
    .in_eop    (a_ie),
    .out_valid (a_ov),
    .out_bit   (a_ob),
    .out_sop   (a_os),
    .out_eop   (a_oe),
    .out_len   (a_ol),
    .out_abort (a_oa),
    .stuff_err (a_se)
  );

  usb_bit_unstuff #(.HDR_BITS(0)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_iv),
    .in_bit    (b_ib),
    .in_sop    (b_is),
    .in_eop    (b_ie),
    .out_valid (b_ov),
    .out_bit   (b_ob),
    .out_sop   (b_os),
    .out_eop   (b_oe),
    .out_len   (b_ol),
    .out_abort (b_oa),
    .stuff_err (b_se)
  );

  function automatic string fmt(input ev_t e);
    return $sformatf("v=%0b b=%0b sop=%0b eop=%0b abt=%0b err=%0b len=%0d",
                     e.v, e.b, e.sop, e.eop, e.abt, e.err, e.len);
  endfunction

  task automatic chk(input int w, input ev_t act);
    ev_t exp;
    bit  ok;
    vec++;
    if ((w == 0 && qa.size() == 0) || (w == 1 && qb.size() == 0)) begin
      bad++;
      $display("FAIL dut%0d unexpected output: got %s want none",
               w, fmt(act));
    end else begin
      exp = (w == 0) ? qa.pop_front() : qb.pop_front();
      ok = act.v == exp.v && act.sop == exp.sop && act.eop == exp.eop &&
           act.abt == exp.abt && act.err == exp.err &&
           (!exp.v || act.b == exp.b) &&
           (!exp.eop || act.len == exp.len);
      if (!ok) begin
        bad++;
        $display("FAIL dut%0d output: got %s want %s",
                 w, fmt(act), fmt(exp));
      end
    end
  endtask

  always @(negedge clk)
    if (rst_n && (a_ov | a_oe | a_oa | a_se))
      chk(0, {a_ov, a_ob, a_os, a_oe, a_oa, a_se, a_ol});

  always @(negedge clk)
    if (rst_n && (b_ov | b_oe | b_oa | b_se))
      chk(1, {b_ov, b_ob, b_os, b_oe, b_oa, b_se, b_ol});

  task automatic put(input int w, input logic v, input logic b,
                     input logic s, input logic e, input logic ab,
                     input logic er, input int len);
    ev_t x;
    x = {v, b, s, e, ab, er, 11'(len)};
    if (w == 0) qa.push_back(x);
    else        qb.push_back(x);
  endtask

  // Expected emitted bits, sop on the first, eop (with len) on the last.
  task automatic ex(input int w, input string s, input bit sop,
                    input bit eop, input int len);
    for (int i = 0; i < s.len(); i++)
      put(w, 1'b1, s[i] == "1", sop && i == 0,
          eop && i == s.len() - 1, 1'b0, 1'b0,
          (eop && i == s.len() - 1) ? len : 0);
  endtask

  task automatic drv(input int w, input logic v, input logic b,
                     input logic s, input logic e);
    @(negedge clk);
    a_iv = (w == 0) & v; a_ib = b; a_is = s; a_ie = e;
    b_iv = (w == 1) & v; b_ib = b; b_is = s; b_ie = e;
  endtask

  task automatic tx(input int w, input string s, input bit sop,
                    input bit eop, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      drv(w, 1'b1, s[i] == "1", sop && i == 0, eop && i == s.len() - 1);
      if (gaps)
        repeat ($urandom_range(0, 2)) drv(w, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic drain(input string name);
    repeat (3) drv(0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    vec++;
    if (qa.size() != 0 || qb.size() != 0) begin
      bad++;
      $display("FAIL %s drain: got %0d/%0d pending want 0/0",
               name, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  task automatic zchk(input string name);
    logic [35:0] all;
    all = {a_ov, a_ob, a_os, a_oe, a_oa, a_se, a_ol,
           b_ov, b_ob, b_os, b_oe, b_oa, b_se, b_ol};
    vec++;
    if (all != '0) begin
      bad++;
      $display("FAIL %s zero outputs: got %h want 0", name, all);
    end
  endtask

  task automatic t1(input bit gaps);
    ex(0, "10010110", 1, 0, 0);
    ex(0, "111111", 0, 0, 0);
    ex(0, "10110", 0, 1, 11);
    tx(0, "10010110", 1, 0, gaps);
    tx(0, "111111010110", 0, 1, gaps);
    drain(gaps ? "t1_gaps" : "t1");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    zchk("reset");
    rst_n = 1'b1;

    t1(1'b0);

    // stuff error, then bits discarded until eop
    ex(0, "10010110", 1, 0, 0);
    ex(0, "111111", 0, 0, 0);
    put(0, 0, 0, 0, 0, 1, 1, 0);
    tx(0, "10010110", 1, 0, 0);
    tx(0, "1111111010", 0, 1, 0);
    drain("stuff_err");

    // error, then a one-bit packet re-syncs out of ERR
    ex(0, "10010110", 1, 0, 0);
    ex(0, "111111", 0, 0, 0);
    put(0, 0, 0, 0, 0, 1, 1, 0);
    put(0, 1, 0, 1, 1, 1, 0, 0);
    tx(0, "10010110", 1, 0, 0);
    tx(0, "11111110", 0, 0, 0);
    tx(0, "0", 1, 1, 0);
    drain("err_resync");

    // eop on a dropped stuffed bit
    ex(0, "10010110", 1, 0, 0);
    ex(0, "0111111", 0, 0, 0);
    put(0, 0, 0, 0, 1, 0, 0, 7);
    tx(0, "10010110", 1, 0, 0);
    tx(0, "01111110", 0, 1, 0);
    drain("eop_on_stuff");

    // header ones never count toward a run
    ex(0, "11111111", 1, 0, 0);
    ex(0, "0111111", 0, 0, 0);
    ex(0, "1", 0, 1, 8);
    tx(0, "11111111", 1, 0, 0);
    tx(0, "011111101", 0, 1, 0);
    drain("hdr_ones");

    // sop mid-body aborts and restarts
    ex(0, "10010110", 1, 0, 0);
    ex(0, "101", 0, 0, 0);
    put(0, 1, 1, 1, 0, 1, 0, 0);
    ex(0, "0010110", 0, 0, 0);
    ex(0, "01", 0, 1, 2);
    tx(0, "10010110", 1, 0, 0);
    tx(0, "101", 0, 0, 0);
    tx(0, "1", 1, 0, 0);
    tx(0, "0010110", 0, 0, 0);
    tx(0, "01", 0, 1, 0);
    drain("resync");

    // short packet ending in header, and a one-bit packet
    ex(0, "1011", 1, 1, 0);
    tx(0, "1011", 1, 1, 0);
    ex(0, "1", 1, 1, 0);
    tx(0, "1", 1, 1, 0);
    drain("short");

    // HDR_BITS=0: first bit is a body bit
    ex(1, "1", 1, 1, 1);
    tx(1, "1", 1, 1, 0);
    ex(1, "1111110", 1, 1, 7);
    tx(1, "11111100", 1, 1, 0);
    drain("hdr0");

    t1(1'b1);

    // reset mid-body
    ex(0, "10010110", 1, 0, 0);
    ex(0, "111", 0, 0, 0);
    tx(0, "10010110", 1, 0, 0);
    tx(0, "111", 0, 0, 0);
    drain("pre_reset");
    #2 rst_n = 1'b0;
    #1 zchk("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 zchk("post_reset");
    t1(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
